// File: rtl/pc_gen.sv
// Registered program counter with four next-PC sources, misalignment trap and
// an optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(4),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic [WIDTH-1:0] rs1,
  input  logic             is_call,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus4,
  output logic             misaligned,
  output logic [WIDTH-1:0] bad_target,
  output logic             ras_empty
);

  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] jr;
  logic [WIDTH-1:0] ret;
  logic [WIDTH-1:0] target;
  logic             mis;

  assign inc      = PC + WIDTH'(4);
  assign br       = PC + ImmOp;
  assign jr       = (rs1 + ImmOp) & ~WIDTH'(1);
  assign PC_plus4 = inc;

  always_comb begin
    target = inc;
    unique case (PCsrc)
      2'b00: target = inc;
      2'b01: target = br;
      2'b10: target = jr;
      2'b11: target = ret;
    endcase
    mis = (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC         <= RESET_VECTOR;
      misaligned <= 1'b0;
      bad_target <= '0;
    end else begin
      misaligned <= 1'b0;
      if (en) begin
        if (mis) begin
          PC         <= TRAP_VECTOR;
          misaligned <= 1'b1;
          bad_target <= target;
        end else begin
          PC <= target;
        end
      end
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_nxt;
  logic [PW-1:0]    wr_addr;
  logic [PW:0]      count;
  logic [PW:0]      count_nxt;
  logic             wr_en;
  logic             has_entry;

  assign has_entry = (count != '0);
  assign ras_empty = !has_entry;
  // An empty stack falls back to the sequential address rather than trapping.
  assign ret       = has_entry ? ras_mem[top] : inc;

  always_comb begin
    top_nxt   = top;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_addr   = top + PW'(1);
    if (en && !mis) begin
      if (is_call && (PCsrc == 2'b11)) begin
        // Return-and-call: replace the popped entry in place, depth unchanged.
        wr_en   = 1'b1;
        wr_addr = top;
      end else if (is_call) begin
        wr_en   = 1'b1;
        top_nxt = top + PW'(1);
        if (count != FULL) count_nxt = count + (PW+1)'(1);
      end else if ((PCsrc == 2'b11) && has_entry) begin
        top_nxt   = top - PW'(1);
        count_nxt = count - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top   <= '0;
      count <= '0;
    end else begin
      top   <= top_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_addr] <= inc;
  end
`else
  logic unused_is_call;

  assign unused_is_call = is_call;
  assign ret            = inc;
  assign ras_empty      = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against a queue-based reference model.
module tb_pc_gen;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0004;
  localparam int unsigned DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  PCsrc;
  logic [31:0] ImmOp;
  logic [31:0] rs1;
  logic        is_call;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        misaligned;
  logic [31:0] bad_target;
  logic        ras_empty;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_bad;
  logic        m_mis;
  logic [31:0] m_ras [$];

  pc_gen #(
    .WIDTH       (32),
    .RESET_VECTOR(RESET_VEC),
    .TRAP_VECTOR (TRAP_VEC),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .PCsrc     (PCsrc),
    .ImmOp     (ImmOp),
    .rs1       (rs1),
    .is_call   (is_call),
    .PC        (PC),
    .PC_plus4  (PC_plus4),
    .misaligned(misaligned),
    .bad_target(bad_target),
    .ras_empty (ras_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_empty();
`ifdef PC_RAS_EN
    return (m_ras.size() == 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_all();
    check("PC", PC, m_pc);
    check("PC_plus4", PC_plus4, m_pc + 32'd4);
    check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    check("bad_target", bad_target, m_bad);
    check("ras_empty", {31'b0, ras_empty}, {31'b0, exp_empty()});
  endtask

  task automatic model_reset();
    m_pc  = RESET_VEC;
    m_bad = '0;
    m_mis = 1'b0;
    m_ras.delete();
  endtask

  // Next-PC rules applied to the model state for one clock edge.
  task automatic model_step(input logic e, input logic [1:0] src, input logic [31:0] imm,
                            input logic [31:0] r1, input logic call);
    logic [31:0] nxt;
    logic [31:0] tgt;
    nxt = m_pc + 32'd4;
    case (src)
      2'd0: tgt = nxt;
      2'd1: tgt = m_pc + imm;
      2'd2: tgt = (r1 + imm) & 32'hFFFF_FFFE;
      default: begin
`ifdef PC_RAS_EN
        tgt = (m_ras.size() > 0) ? m_ras[$] : nxt;
`else
        tgt = nxt;
`endif
      end
    endcase
    m_mis = 1'b0;
    if (e) begin
      if (tgt[1:0] != 2'b00) begin
        m_pc  = TRAP_VEC;
        m_mis = 1'b1;
        m_bad = tgt;
      end else begin
        m_pc = tgt;
`ifdef PC_RAS_EN
        if (src == 2'd3 && call) begin
          if (m_ras.size() > 0) m_ras[m_ras.size()-1] = nxt;
        end else if (call) begin
          m_ras.push_back(nxt);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (src == 2'd3 && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
`endif
      end
    end
  endtask

  task automatic step(input logic e, input logic [1:0] src, input logic [31:0] imm,
                      input logic [31:0] r1, input logic call);
    en      = e;
    PCsrc   = src;
    ImmOp   = imm;
    rs1     = r1;
    is_call = call;
    model_step(e, src, imm, r1, call);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    PCsrc   = 2'd0;
    ImmOp   = '0;
    rs1     = '0;
    is_call = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset
    repeat (3) step(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // Branch back by 8 from 0x100, then stall
    step(1'b1, 2'd2, 32'h0, 32'h100, 1'b0);
    step(1'b1, 2'd1, 32'hFFFF_FFF8, 32'h0, 1'b0);
    step(1'b0, 2'd1, 32'h40, 32'h0, 1'b0);
    step(1'b0, 2'd2, 32'h0, 32'h3, 1'b1);

    // Misaligned indirect jump traps; bad_target holds afterwards
    step(1'b1, 2'd2, 32'h0, 32'h203, 1'b0);
    step(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // Call then return
    step(1'b1, 2'd2, 32'h0, 32'h40, 1'b0);
    step(1'b1, 2'd1, 32'h100, 32'h0, 1'b1);
    step(1'b1, 2'd3, 32'h0, 32'h0, 1'b0);

    // Overflow the stack by one, then drain it and pop once more
    repeat (DEPTH + 1) step(1'b1, 2'd1, 32'h10, 32'h0, 1'b1);
    repeat (DEPTH + 1) step(1'b1, 2'd3, 32'h0, 32'h0, 1'b0);

    // Return-and-call on empty and on non-empty stack
    step(1'b1, 2'd3, 32'h0, 32'h0, 1'b1);
    step(1'b1, 2'd1, 32'h20, 32'h0, 1'b1);
    step(1'b1, 2'd3, 32'h0, 32'h0, 1'b1);
    step(1'b1, 2'd3, 32'h0, 32'h0, 1'b0);

    // Wrap around the top of the address space
    step(1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      logic [31:0] r1;
      imm = $urandom;
      r1  = $urandom;
      if ($urandom_range(0, 5) != 0) imm[1:0] = 2'b00;
      if ($urandom_range(0, 5) != 0) r1[1:0]  = 2'b00;
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), imm, r1,
           $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset mid-cycle
    step(1'b1, 2'd1, 32'h80, 32'h0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 2'd3, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Sequential program-counter generator for the single-cycle RV32I core. It replaces the combinational next-PC adder by owning the PC register itself. Each enabled cycle it selects one of four next-PC sources: sequential, PC-relative branch, register-indirect jump, or predicted return. It checks every target for alignment and redirects misaligned targets to a trap vector. An optional return-address stack (RAS) supplies return targets.

## Interface
- WIDTH, 32, datapath/address width (>= 8)
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0004, PC value loaded on misaligned target
- RAS_DEPTH, 4, return-address-stack entries (power of two, >= 2)

- clk  input  1  core clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  1 = advance PC this cycle; 0 = stall (no state change)
- PCsrc  input  2  00 = PC+4, 01 = PC+ImmOp, 10 = (rs1+ImmOp)&~1, 11 = RAS pop
- ImmOp  input  WIDTH  sign-extended immediate
- rs1  input  WIDTH  register operand for indirect jumps
- is_call  input  1  push PC+4 onto the RAS this cycle (JAL/JALR with rd=x1/x5)
- PC  output  WIDTH  current PC (registered)
- PC_plus4  output  WIDTH  PC+4 (combinational, for the rd writeback of JAL/JALR)
- misaligned  output  1  registered one-cycle pulse; the previous cycle's target was misaligned
- bad_target  output  WIDTH  last misaligned target; holds its value until the next trap
- ras_empty  output  1  RAS holds no valid entries

## Operation
- Target computation (WIDTH-bit, wrap modulo 2^WIDTH, carries discarded):
  - inc = PC+4
  - br = PC+ImmOp
  - jr = (rs1+ImmOp) with bit0 forced to 0
  - ret = RAS top
- Target is chosen by PCsrc.
- Alignment check: target[1:0] != 2'b00 makes the target misaligned (bit0 of jr is already cleared, so only bit1 is checked for jr).
- On an enabled cycle:
  - aligned target: PC <= target, misaligned <= 0
  - misaligned target: PC <= TRAP_VECTOR, misaligned <= 1, bad_target <= target, and RAS push/pop are suppressed
- en=0: PC, RAS, bad_target hold; misaligned <= 0.
- RAS (PC_RAS_EN defined):
  - Circular buffer of RAS_DEPTH entries, with top pointer and count 0..RAS_DEPTH.
  - Push (is_call=1, en=1, no trap): writes PC+4 at top+1 and advances top. count saturates at RAS_DEPTH. A push when full overwrites the oldest entry.
  - Pop (PCsrc=11, en=1, no trap), count>0: target = entry[top], then top decrements and count decrements.
  - Pop with count=0: target = PC+4, no state change, no trap.
  - Simultaneous pop and push (PCsrc=11 with is_call=1): pop target is used, and the top entry is replaced in place by PC+4. count is unchanged (0 stays 0 and the entry is written but remains invalid).
  - ras_empty = (count==0).

## Timing
- Reset (rst_n low, asynchronous): PC=RESET_VECTOR, misaligned=0, bad_target=0, RAS count=0, top=0, ras_empty=1. Deassertion is synchronised externally; the first edge with rst_n=1 may update state.
- Latency: the target is computed combinationally in cycle N and is visible on PC after edge N+1. misaligned is valid in the same cycle that PC shows TRAP_VECTOR.
- PC_plus4 tracks PC with zero latency.
- Reset mid-operation clears the RAS immediately; there is no partial state.

## Configuration
- PC_RAS_EN defined: RAS logic is present as described above, and PCsrc=11 pops.
- PC_RAS_EN undefined:
  - no RAS storage
  - PCsrc=11 selects PC+4
  - is_call is ignored
  - ras_empty is tied to 1
  - all other behaviour is identical

## Test plan
- Reset then 3 cycles with en=1, PCsrc=00 -> PC = 0x0, 0x4, 0x8, 0xC; misaligned stays 0.
- PC=0x100, PCsrc=01, ImmOp=-8 (0xFFFF_FFF8) -> PC=0x0F8. Then en=0 for 2 cycles -> PC holds 0x0F8.
- PCsrc=10, rs1=0x203, ImmOp=0 -> PC=0x202 misaligned -> PC=TRAP_VECTOR, misaligned=1 for one cycle, bad_target=0x202.
- PC_RAS_EN:
  - Call at PC=0x40 (is_call=1, PCsrc=01, ImmOp=0x100), then return (PCsrc=11) -> PC=0x140 then 0x44; ras_empty goes 1→0→1.
  - Push RAS_DEPTH+1 calls (return addresses A0..A4), then pop 4 times -> A4, A3, A2, A1. A fifth pop gives PC+4 with ras_empty=1.
- PC=0xFFFF_FFFC, PCsrc=00 -> PC wraps to 0x0; assert rst_n low mid-cycle -> PC=RESET_VECTOR before the next edge.
